// File: rtl/coo_edge_fetch_if.sv
// Control, COO memory read port and edge stream of coo_edge_fetch.
// master = the fetch engine, slave = its environment (memory, decoder, controller).
interface coo_edge_fetch_if #(
  parameter int unsigned COO_BW = 3,
  parameter int unsigned ADDR_W = 3
);
  logic                start;
  logic                coo_rd_en;
  logic [ADDR_W-1:0]   coo_addr;
  logic [COO_BW-1:0]   coo_row0;
  logic [COO_BW-1:0]   coo_row1;
  logic [2*COO_BW-1:0] coo_out;
  logic                coo_valid;
  logic                coo_ready;
  logic [ADDR_W-1:0]   edge_idx;
  logic                last;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, coo_row0, coo_row1, coo_ready,
    output coo_rd_en, coo_addr, coo_out, coo_valid, edge_idx, last, busy, done, err
  );

  modport slave (
    output start, coo_row0, coo_row1, coo_ready,
    input  coo_rd_en, coo_addr, coo_out, coo_valid, edge_idx, last, busy, done, err
  );
endinterface

// File: rtl/coo_edge_fetch.sv
// Streams NUM_EDGES COO columns from a 1-cycle-latency memory as packed {row0,row1}
// edges with a valid/ready handshake; flags zero fields when the format is 1-indexed.
module coo_edge_fetch #(
  parameter int unsigned COO_BW          = 3,
  parameter int unsigned NUM_EDGES       = 6,
  parameter int unsigned ADDR_W          = 3,
  parameter bit          COO_ONE_INDEXED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  coo_edge_fetch_if.master bus
);

  localparam int unsigned OUT_W = 2 * COO_BW;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_EDGES - 1);

  if (NUM_EDGES < 1 || NUM_EDGES > (1 << ADDR_W)) begin : g_bad_num_edges
    $error("coo_edge_fetch: NUM_EDGES out of range for ADDR_W");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e             state_q;
  logic               rd_en_q;
  logic [ADDR_W-1:0]  edge_idx_q;
  logic [OUT_W-1:0]   coo_out_q;
  logic               valid_q;
  logic               last_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic field_bad_c;
  logic handshake_c;

  // A zero field is only illegal in the 1-indexed COO format.
  assign field_bad_c = COO_ONE_INDEXED &&
                       ((bus.coo_row0 == '0) || (bus.coo_row1 == '0));
  assign handshake_c = valid_q && bus.coo_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      edge_idx_q <= '0;
      coo_out_q  <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            edge_idx_q <= '0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          state_q <= WAIT;
        end
        WAIT: begin
          coo_out_q <= {bus.coo_row0, bus.coo_row1};
          valid_q   <= 1'b1;
          last_q    <= (edge_idx_q == LAST_IDX);
          if (field_bad_c) begin
            err_q <= 1'b1;
          end
          state_q <= PRESENT;
        end
        PRESENT: begin
          // Output fields hold until the downstream decoder takes the edge.
          if (handshake_c) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              edge_idx_q <= edge_idx_q + ADDR_W'(1);
              rd_en_q    <= 1'b1;
              state_q    <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.coo_rd_en = rd_en_q;
  assign bus.coo_addr  = edge_idx_q;
  assign bus.coo_out   = coo_out_q;
  assign bus.coo_valid = valid_q;
  assign bus.edge_idx  = edge_idx_q;
  assign bus.last      = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/coo_edge_fetch.md
COO_EDGE_FETCH -- requirements
Module: coo_edge_fetch

Interface
REQ-001 The block SHALL have parameter COO_BW, default 3, giving the bit width of each COO field.
REQ-002 The block SHALL have parameter NUM_EDGES, default 6, giving the number of edges (COO columns) to stream; legal range is 1 to 2**ADDR_W.
REQ-003 The block SHALL have parameter ADDR_W, default 3, giving the COO memory address width.
REQ-004 The block SHALL have parameter COO_ONE_INDEXED, default 1; 1 means a field value of 0 is illegal.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, on the ports listed below.
REQ-006 clk  in  1  clock, all state on its rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle request to stream all edges.
REQ-009 coo_rd_en  out  1  COO memory read strobe.
REQ-010 coo_addr  out  ADDR_W  COO column address (0-based).
REQ-011 coo_row0  in  COO_BW  memory row0 (source) data, valid 1 cycle after coo_rd_en.
REQ-012 coo_row1  in  COO_BW  memory row1 (destination) data, valid 1 cycle after coo_rd_en.
REQ-013 coo_out  out  2*COO_BW  packed edge {row0, row1}, for the downstream COO decoder.
REQ-014 coo_valid  out  1  coo_out holds a valid edge.
REQ-015 coo_ready  in  1  downstream accepts the edge.
REQ-016 edge_idx  out  ADDR_W  index of the edge currently presented.
REQ-017 last  out  1  high with coo_valid when edge_idx == NUM_EDGES-1.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse after the final handshake.
REQ-020 err  out  1  sticky flag: an illegal field value was fetched.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, WAIT, PRESENT and DONE.
REQ-022 IDLE: if start=1, the block SHALL clear edge_idx and err and go to FETCH; otherwise it SHALL stay in IDLE.
REQ-023 FETCH: the block SHALL assert coo_rd_en=1 for exactly one cycle with coo_addr=edge_idx, then go to WAIT.
REQ-024 WAIT: the block SHALL register {coo_row0, coo_row1} into coo_out and go to PRESENT.
REQ-025 PRESENT: coo_valid SHALL be 1, and coo_out, edge_idx and last SHALL stay stable until coo_valid&coo_ready.
REQ-026 On a handshake when last=0, the block SHALL increment edge_idx and go to FETCH.
REQ-027 On a handshake when last=1, the block SHALL go to DONE.
REQ-028 DONE: done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; edge_idx SHALL hold its final value.
REQ-029 Throughput SHALL be one edge per 3 cycles when coo_ready is held at 1.
REQ-030 The latency from start to the first coo_valid SHALL be 3 cycles: start in cycle 0 gives valid in cycle 3.
REQ-031 start SHALL be ignored when the FSM is not in IDLE; a stream is never restarted mid-run.
REQ-032 coo_ready while coo_valid=0 SHALL have no effect.
REQ-033 coo_rd_en SHALL be 0 outside FETCH, and coo_addr SHALL always equal edge_idx.
REQ-034 When COO_ONE_INDEXED=1 and either fetched field is 0, err SHALL set in the cycle after WAIT; streaming SHALL continue unchanged.
REQ-035 err SHALL clear only on reset or on an accepted start.
REQ-036 When COO_ONE_INDEXED=0, err SHALL stay 0.
REQ-037 edge_idx SHALL never exceed NUM_EDGES-1, and the address SHALL not wrap within a stream.
REQ-038 With NUM_EDGES=1, the first PRESENT SHALL have last=1 and lead straight to DONE after the handshake.

Reset
REQ-039 On reset assertion, the block SHALL go to IDLE immediately (asynchronously), regardless of state.
REQ-040 Under reset, coo_out, edge_idx, coo_valid, last, busy, done, err and coo_rd_en SHALL be 0, and coo_addr SHALL be 0.
REQ-041 Reset mid-stream SHALL abandon the stream; no done pulse is produced, and the next start restarts from edge 0.

Verification
REQ-042 Memory row0={1,1,2,3,4,5}, row1={2,3,4,5,6,6}, coo_ready=1, pulse start -> coo_out = 6'o12, 6'o13, 6'o24, 6'o35, 6'o46, 6'o56 on cycles 3, 6, 9, 12, 15, 18; last at cycle 18; done at cycle 19.
REQ-043 Hold coo_ready=0 for 5 cycles during edge 2 -> coo_valid stays 1, coo_out=6'o24 stable, coo_rd_en=0; the stream resumes after ready.
REQ-044 Pulse start again while busy -> no effect; exactly 6 handshakes and one done pulse.
REQ-045 Assert reset while in PRESENT at edge 3 -> all outputs 0 asynchronously; the next start streams from edge 0 with 6'o12 first.
REQ-046 Set row0[4]=0 with COO_ONE_INDEXED=1 -> err=1 from edge 4 onward; all 6 edges are still delivered; err clears on the next start.
REQ-047 NUM_EDGES=1 -> exactly one handshake with last=1, then done.
